mux_rr_arbiter: RTL

Registered two-source round-robin arbiter that sits directly upstream of the 4-bit 2:1 mux datapath. It accepts 4-bit words from sources A and B over valid/ready handshakes and picks one per cycle. It presents the winner on a registered output stage together with the matching `sel` value, so that `sel` and data stay aligned for the downstream consumer.

---
 rtl/mux_pkg.sv | 16 +
 rtl/rr_grant_2.sv | 39 +++
 rtl/mux_rr_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared types and constants for the two-source round-robin mux arbiter.
// Holds the arbiter state enum, the sel encodings and the default data width.
package mux_pkg;

   localparam int DEFAULT_WIDTH = 4;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAST_A = 2'd1,
      ST_LAST_B = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_grant_2.sv
// Combinational two-way round-robin grant logic.
// Optional burst priority is enabled by defining MUX_ARB_BURST_EN.
module rr_grant_2
   import mux_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic       a_valid,
   input  logic       b_valid,
   input  arb_state_t state,
   input  logic [3:0] burst_cnt,
   output logic       grant_a,
   output logic       grant_b
);

   localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST - 1);

   logic prio_a;

   // A leads unless A won last; with bursts the owner may keep the lead.
   always_comb begin
      prio_a = (state != ST_LAST_A);
`ifdef MUX_ARB_BURST_EN
      if (state == ST_LAST_A && a_valid && burst_cnt < BURST_LIMIT) begin
         prio_a = 1'b1;
      end else if (state == ST_LAST_B && b_valid && burst_cnt < BURST_LIMIT) begin
         prio_a = 1'b0;
      end
`endif
      grant_a = a_valid && (prio_a || !b_valid);
      grant_b = b_valid && (!prio_a || !a_valid);
   end

`ifndef MUX_ARB_BURST_EN
   logic unused_burst;
   assign unused_burst = ^{burst_cnt, BURST_LIMIT};
`endif

endmodule

// File: rtl/mux_rr_arbiter.sv
// Registered two-source round-robin arbiter feeding the 4-bit 2:1 mux datapath.
// Define MUX_ARB_BURST_EN to let a source hold the grant for up to MAX_BURST words.
module mux_rr_arbiter
   import mux_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [WIDTH-1:0] b,
   input  logic             b_valid,
   output logic             b_ready,
   output logic [WIDTH-1:0] y,
   output logic             y_valid,
   input  logic             y_ready,
   output logic             sel
);

   arb_state_t       state_q, state_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             y_valid_q, y_valid_d;
   logic             sel_q, sel_d;
   logic             load;
   logic             grant_a, grant_b;
   logic [3:0]       burst_cnt;

   rr_grant_2 #(
      .MAX_BURST (MAX_BURST)
   ) u_grant (
      .a_valid   (a_valid),
      .b_valid   (b_valid),
      .state     (state_q),
      .burst_cnt (burst_cnt),
      .grant_a   (grant_a),
      .grant_b   (grant_b)
   );

   assign load    = !y_valid_q || y_ready;
   assign a_ready = load && grant_a;
   assign b_ready = load && grant_b;

   // Output stage and priority FSM only move when the output register can load.
   always_comb begin
      state_d   = state_q;
      y_d       = y_q;
      sel_d     = sel_q;
      y_valid_d = y_valid_q;
      if (load) begin
         y_valid_d = a_ready || b_ready;
         if (a_ready) begin
            y_d     = a;
            sel_d   = SEL_A;
            state_d = ST_LAST_A;
         end else if (b_ready) begin
            y_d     = b;
            sel_d   = SEL_B;
            state_d = ST_LAST_B;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         y_q       <= '0;
         sel_q     <= SEL_A;
         y_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         y_q       <= y_d;
         sel_q     <= sel_d;
         y_valid_q <= y_valid_d;
      end
   end

`ifdef MUX_ARB_BURST_EN
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] cnt_inc;

   assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

   // Counts repeat grants to the current owner; any hand-off or owner idle clears it.
   always_comb begin
      cnt_d = cnt_q;
      if (a_ready) begin
         cnt_d = (state_q == ST_LAST_A) ? cnt_inc : 4'd0;
      end else if (b_ready) begin
         cnt_d = (state_q == ST_LAST_B) ? cnt_inc : 4'd0;
      end else if ((state_q == ST_LAST_A && !a_valid) ||
                   (state_q == ST_LAST_B && !b_valid)) begin
         cnt_d = 4'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign burst_cnt = cnt_q;
`else
   assign burst_cnt = 4'd0;
`endif

   assign y       = y_q;
   assign y_valid = y_valid_q;
   assign sel     = sel_q;

endmodule
